// File: rtl/command_out_writer_if.sv
// Command stream from the accelerators into the command-out writer.
// One shared AXI-Stream; tid names the accelerator that sent the beat.
interface command_out_writer_if #(
  parameter int ACC_BITS = 4
);
  logic [63:0]         tdata;
  logic                tvalid;
  logic                tready;
  logic [ACC_BITS-1:0] tid;
  logic                tlast;

  modport master (output tdata, output tvalid, output tid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tid, input tlast, output tready);
endinterface

// File: rtl/command_out_writer.sv
// Writes accelerator completion commands into per-accelerator circular
// subqueues of the command-out BRAM. Payload beats go first and the header
// (with its valid byte set) goes last, so the host never sees a partial entry.
// The target slot range is polled free before any beat is accepted.
module command_out_writer #(
  parameter int MAX_ACCS      = 16,
  parameter int ACC_BITS      = $clog2(MAX_ACCS),
  parameter int SUBQUEUE_BITS = 6,
  parameter int RETRY_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  command_out_writer_if.slave in_stream,
  output logic [31:0]         cmdout_queue_addr,
  output logic                cmdout_queue_en,
  output logic [7:0]          cmdout_queue_we,
  output logic [63:0]         cmdout_queue_din,
  input  logic [63:0]         cmdout_queue_dout,
  output logic                cmdout_queue_clk,
  output logic                cmdout_queue_rst,
  output logic                acc_avail_wr,
  output logic [ACC_BITS-1:0] acc_avail_wr_address,
  output logic                protocol_err
);

  localparam int CNT_BITS = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_SLOT  = 3'd1;
  localparam logic [2:0] CHK_SLOT = 3'd2;
  localparam logic [2:0] BACKOFF  = 3'd3;
  localparam logic [2:0] ACC_HDR  = 3'd4;
  localparam logic [2:0] PAYLOAD  = 3'd5;
  localparam logic [2:0] WR_HDR   = 3'd6;

  logic [2:0]               state_q, state_d;
  logic [ACC_BITS-1:0]      id_q, id_d;
  logic [3:0]               n_q, n_d;
  logic [3:0]               k_q, k_d;
  logic [55:0]              hdr_q, hdr_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [SUBQUEUE_BITS-1:0] idx_q [MAX_ACCS];
  logic [SUBQUEUE_BITS-1:0] idx_d [MAX_ACCS];

  logic                     tready_c;
  logic [SUBQUEUE_BITS-1:0] slot_c;
  logic                     slot_busy;
  logic                     len_bad;
  logic [55:0]              unused_dout;

  assign slot_busy        = (cmdout_queue_dout[63:56] != 8'h00);
  assign unused_dout      = cmdout_queue_dout[55:0];
  assign len_bad          = (in_stream.tlast && (k_q != n_q)) || (!in_stream.tlast && (k_q == n_q));
  assign in_stream.tready = tready_c;
  assign cmdout_queue_clk = clk;
  assign cmdout_queue_rst = 1'b0;
  assign protocol_err     = err_q;

  // Sequencer: latch the header, poll the slot range, then stream payload and header into the queue.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    n_d     = n_q;
    k_d     = k_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_stream.tvalid) begin
          id_d    = in_stream.tid;
          n_d     = in_stream.tdata[11:8];
          hdr_d   = in_stream.tdata[55:0];
          k_d     = 4'd0;
          state_d = RD_SLOT;
        end
      end
      RD_SLOT: begin
        state_d = CHK_SLOT;
      end
      CHK_SLOT: begin
        if (slot_busy) begin
          cnt_d   = CNT_BITS'(RETRY_CYCLES - 1);
          state_d = BACKOFF;
        end else if (k_q == n_q) begin
          state_d = ACC_HDR;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = RD_SLOT;
        end
      end
      BACKOFF: begin
        if (cnt_q == '0) begin
          k_d     = 4'd0;
          state_d = RD_SLOT;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      ACC_HDR: begin
        if (in_stream.tlast && (n_q != 4'd0)) begin
          err_d = 1'b1;
        end
        if (n_q == 4'd0) begin
          state_d = WR_HDR;
        end else begin
          k_d     = 4'd1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (in_stream.tvalid) begin
          if (len_bad) begin
            err_d = 1'b1;
          end
          if (k_q == n_q) begin
            state_d = WR_HDR;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      WR_HDR: begin
        idx_d[id_q] = idx_q[id_q] + SUBQUEUE_BITS'(n_q) + SUBQUEUE_BITS'(1);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // BRAM port, stream ready and availability pulse; all forced quiet while reset is held.
  always_comb begin
    tready_c             = 1'b0;
    cmdout_queue_en      = 1'b0;
    cmdout_queue_we      = 8'h00;
    cmdout_queue_din     = 64'h0;
    acc_avail_wr         = 1'b0;
    acc_avail_wr_address = '0;
    slot_c               = idx_q[id_q] + SUBQUEUE_BITS'(k_q);
    case (state_q)
      RD_SLOT: begin
        cmdout_queue_en = 1'b1;
      end
      ACC_HDR: begin
        tready_c = 1'b1;
      end
      PAYLOAD: begin
        tready_c = 1'b1;
        if (in_stream.tvalid) begin
          cmdout_queue_en  = 1'b1;
          cmdout_queue_we  = 8'hFF;
          cmdout_queue_din = in_stream.tdata;
        end
      end
      WR_HDR: begin
        slot_c               = idx_q[id_q];
        cmdout_queue_en      = 1'b1;
        cmdout_queue_we      = 8'hFF;
        cmdout_queue_din     = {8'h80, hdr_q};
        acc_avail_wr         = 1'b1;
        acc_avail_wr_address = id_q;
      end
      default: begin
        tready_c = 1'b0;
      end
    endcase
    if (!rstn) begin
      tready_c             = 1'b0;
      cmdout_queue_en      = 1'b0;
      cmdout_queue_we      = 8'h00;
      cmdout_queue_din     = 64'h0;
      acc_avail_wr         = 1'b0;
      acc_avail_wr_address = '0;
    end
    cmdout_queue_addr = 32'({id_q, slot_c, 3'b000});
  end

  // State registers with synchronous active-low reset; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      id_q    <= '0;
      n_q     <= 4'd0;
      k_q     <= 4'd0;
      hdr_q   <= 56'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_ACCS; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      n_q     <= n_d;
      k_q     <= k_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_command_out_writer.sv
// Directed bench for command_out_writer: a BRAM model with 1-cycle read
// latency, a write/poll/availability log, and hand-computed expectations.
module tb_command_out_writer;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] din;
    logic [7:0]  we;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cmdout_queue_addr;
  logic        cmdout_queue_en;
  logic [7:0]  cmdout_queue_we;
  logic [63:0] cmdout_queue_din;
  logic [63:0] cmdout_queue_dout = 64'h0;
  logic        cmdout_queue_clk;
  logic        cmdout_queue_rst;
  logic        acc_avail_wr;
  logic [3:0]  acc_avail_wr_address;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [1024];
  wr_t         wlog [$];
  int          availLog [$];
  int          pollLog [$];
  int          cyc = 0;
  int          availCyc = 0;
  int          treadyCnt = 0;
  logic        rdPend = 1'b0;
  logic [9:0]  rdIdx = '0;

  int          hostSeq = 0;
  int          hostSeen = 0;
  int          hostKind = 0;
  int          hostIdx = 0;
  logic [63:0] hostData = 64'h0;

  command_out_writer_if #(.ACC_BITS(4)) ifc ();

  command_out_writer dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .in_stream            (ifc),
    .cmdout_queue_addr    (cmdout_queue_addr),
    .cmdout_queue_en      (cmdout_queue_en),
    .cmdout_queue_we      (cmdout_queue_we),
    .cmdout_queue_din     (cmdout_queue_din),
    .cmdout_queue_dout    (cmdout_queue_dout),
    .cmdout_queue_clk     (cmdout_queue_clk),
    .cmdout_queue_rst     (cmdout_queue_rst),
    .acc_avail_wr         (acc_avail_wr),
    .acc_avail_wr_address (acc_avail_wr_address),
    .protocol_err         (protocol_err)
  );

  always #5 clk = ~clk;

  // BRAM model and bus monitor, sampled mid-cycle; also carries out host-side memory edits.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc == 1) begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
    end
    if (hostSeq != hostSeen) begin
      hostSeen = hostSeq;
      if (hostKind == 1) begin
        for (int i = 0; i < 64; i++) mem[hostIdx * 64 + i] = 64'h0;
      end else begin
        mem[hostIdx] = hostData;
      end
    end
    rdPend = 1'b0;
    if (cmdout_queue_en) begin
      rdPend = 1'b1;
      rdIdx  = cmdout_queue_addr[12:3];
      if (cmdout_queue_we != 8'h00) begin
        wr_t w;
        w.addr = cmdout_queue_addr;
        w.din  = cmdout_queue_din;
        w.we   = cmdout_queue_we;
        wlog.push_back(w);
        for (int b = 0; b < 8; b++) begin
          if (cmdout_queue_we[b]) mem[rdIdx][b*8 +: 8] = cmdout_queue_din[b*8 +: 8];
        end
      end else if (cmdout_queue_addr == 32'd8) begin
        pollLog.push_back(cyc);
      end
    end
    if (acc_avail_wr) begin
      availLog.push_back(int'(acc_avail_wr_address));
      availCyc = cyc;
    end
    if (ifc.tready) treadyCnt = treadyCnt + 1;
  end

  // Registered read port: data for the address presented this cycle appears after the edge.
  always @(posedge clk) begin
    if (rdPend) cmdout_queue_dout <= mem[rdIdx];
  end

  // Guard against a hung run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expAddr(input int acc, input int slot);
    return 32'((acc << 9) | ((slot & 63) << 3));
  endfunction

  function automatic logic [63:0] hdrOf(input int id, input int n);
    return {8'h00, 36'h0, 8'(id), 4'(n), 8'h5A};
  endfunction

  function automatic logic [63:0] payOf(input int id, input int i);
    return {8'hC5, 40'h12_3456_789A, 8'(id), 8'(i)};
  endfunction

  function automatic logic [63:0] hdrWord(input logic [63:0] h);
    return {8'h80, h[55:0]};
  endfunction

  task automatic hostOp(input int kind, input int idx, input logic [63:0] data);
    hostKind = kind;
    hostIdx  = idx;
    hostData = data;
    hostSeq  = hostSeq + 1;
    @(negedge clk);
    #1;
  endtask

  // Present one beat and hold it until the handshake, within a cycle budget.
  task automatic applyStimulus(input logic [63:0] data, input int id, input logic last, input int budget);
    int n;
    n = 0;
    ifc.tdata  = data;
    ifc.tid    = 4'(id);
    ifc.tlast  = last;
    ifc.tvalid = 1'b1;
    @(negedge clk);
    while (!ifc.tready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("handshake", {63'h0, ifc.tready}, 64'h1);
    @(posedge clk);
    #1;
    ifc.tvalid = 1'b0;
  endtask

  task automatic waitAvail(input int budget);
    int base;
    int n;
    base = availLog.size();
    n = 0;
    while (availLog.size() == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("avail_seen", 64'(availLog.size() - base), 64'h1);
  endtask

  task automatic applyCommand(input int id, input int n);
    applyStimulus(hdrOf(id, n), id, n == 0, 40);
    for (int i = 1; i <= n; i++) applyStimulus(payOf(id, i), id, i == n, 10);
    waitAvail(10);
    hostOp(1, id, 64'h0);
  endtask

  initial begin
    int c0;
    int bW;
    int bA;
    int bP;
    int bT;
    logic [63:0] h;

    rstn       = 1'b0;
    ifc.tvalid = 1'b0;
    ifc.tdata  = 64'h0;
    ifc.tid    = 4'd0;
    ifc.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tready", {63'h0, ifc.tready}, 64'h0);
    checkOutput("rst_en", {63'h0, cmdout_queue_en}, 64'h0);
    checkOutput("rst_we", {56'h0, cmdout_queue_we}, 64'h0);
    checkOutput("rst_din", cmdout_queue_din, 64'h0);
    checkOutput("rst_avail", {63'h0, acc_avail_wr}, 64'h0);
    checkOutput("rst_avail_addr", {60'h0, acc_avail_wr_address}, 64'h0);
    checkOutput("rst_err", {63'h0, protocol_err}, 64'h0);
    checkOutput("rst_bram_rst", {63'h0, cmdout_queue_rst}, 64'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] header-only command");
    bW = wlog.size();
    bA = availLog.size();
    c0 = cyc;
    applyStimulus(64'h0000_0000_0000_0003, 3, 1'b1, 10);
    waitAvail(10);
    checkOutput("ho_latency", 64'(availCyc - c0), 64'd5);
    checkOutput("ho_nwrites", 64'(wlog.size() - bW), 64'd1);
    checkOutput("ho_addr", {32'h0, wlog[bW].addr}, {32'h0, expAddr(3, 0)});
    checkOutput("ho_din", wlog[bW].din, 64'h8000_0000_0000_0003);
    checkOutput("ho_we", {56'h0, wlog[bW].we}, 64'hFF);
    checkOutput("ho_avail_addr", 64'(availLog[bA]), 64'd3);
    hostOp(1, 3, 64'h0);
    applyCommand(3, 0);
    checkOutput("ho_idx3", {32'h0, wlog[wlog.size() - 1].addr}, {32'h0, expAddr(3, 1)});

    $display("[TB] payload with stall");
    bW = wlog.size();
    bA = availLog.size();
    applyStimulus(64'h00AB_CDEF_0123_4211, 5, 1'b0, 10);
    applyStimulus(64'hA5A5_0000_1111_2222, 5, 1'b0, 10);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pl_gap_writes", 64'(wlog.size() - bW), 64'd1);
    applyStimulus(64'hB6B6_3333_4444_5555, 5, 1'b1, 10);
    waitAvail(10);
    checkOutput("pl_nwrites", 64'(wlog.size() - bW), 64'd3);
    checkOutput("pl_a_addr", {32'h0, wlog[bW].addr}, {32'h0, expAddr(5, 1)});
    checkOutput("pl_a_din", wlog[bW].din, 64'hA5A5_0000_1111_2222);
    checkOutput("pl_b_addr", {32'h0, wlog[bW + 1].addr}, {32'h0, expAddr(5, 2)});
    checkOutput("pl_b_din", wlog[bW + 1].din, 64'hB6B6_3333_4444_5555);
    checkOutput("pl_h_addr", {32'h0, wlog[bW + 2].addr}, {32'h0, expAddr(5, 0)});
    checkOutput("pl_h_din", wlog[bW + 2].din, 64'h80AB_CDEF_0123_4211);
    checkOutput("pl_avail_addr", 64'(availLog[bA]), 64'd5);
    hostOp(1, 5, 64'h0);
    applyCommand(5, 0);
    checkOutput("pl_idx5", {32'h0, wlog[wlog.size() - 1].addr}, {32'h0, expAddr(5, 3)});

    $display("[TB] occupied slot back-off");
    hostOp(2, 1, 64'h8000_0000_0000_0000);
    bP = pollLog.size();
    bT = treadyCnt;
    ifc.tdata  = 64'h0000_0000_0000_0107;
    ifc.tid    = 4'd0;
    ifc.tlast  = 1'b0;
    ifc.tvalid = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    checkOutput("occ_blocked", 64'(treadyCnt - bT), 64'd0);
    checkOutput("occ_polls_ge2", {63'h0, (pollLog.size() - bP) >= 2}, 64'h1);
    checkOutput("occ_period", 64'(pollLog[bP + 1] - pollLog[bP]), 64'd20);
    hostOp(2, 1, 64'h0);
    bW = wlog.size();
    applyStimulus(64'h0000_0000_0000_0107, 0, 1'b0, 24);
    applyStimulus(64'hC0C0_0000_0000_0001, 0, 1'b1, 10);
    waitAvail(10);
    checkOutput("occ_p_addr", {32'h0, wlog[bW].addr}, {32'h0, expAddr(0, 1)});
    checkOutput("occ_h_din", wlog[bW + 1].din, 64'h8000_0000_0000_0107);
    hostOp(1, 0, 64'h0);

    $display("[TB] subqueue wrap");
    applyCommand(2, 15);
    applyCommand(2, 15);
    applyCommand(2, 15);
    applyCommand(2, 13);
    bW = wlog.size();
    applyCommand(2, 3);
    h = hdrOf(2, 3);
    checkOutput("wr_nwrites", 64'(wlog.size() - bW), 64'd4);
    checkOutput("wr_p1_addr", {32'h0, wlog[bW].addr}, {32'h0, expAddr(2, 63)});
    checkOutput("wr_p1_din", wlog[bW].din, payOf(2, 1));
    checkOutput("wr_p2_addr", {32'h0, wlog[bW + 1].addr}, {32'h0, expAddr(2, 0)});
    checkOutput("wr_p3_addr", {32'h0, wlog[bW + 2].addr}, {32'h0, expAddr(2, 1)});
    checkOutput("wr_p3_din", wlog[bW + 2].din, payOf(2, 3));
    checkOutput("wr_h_addr", {32'h0, wlog[bW + 3].addr}, {32'h0, expAddr(2, 62)});
    checkOutput("wr_h_din", wlog[bW + 3].din, hdrWord(h));
    applyCommand(2, 0);
    checkOutput("wr_idx2", {32'h0, wlog[wlog.size() - 1].addr}, {32'h0, expAddr(2, 2)});

    $display("[TB] length mismatch");
    checkOutput("lm_err_before", {63'h0, protocol_err}, 64'h0);
    bW = wlog.size();
    bA = availLog.size();
    applyStimulus(hdrOf(7, 2), 7, 1'b0, 40);
    applyStimulus(payOf(7, 1), 7, 1'b1, 10);
    applyStimulus(payOf(7, 2), 7, 1'b1, 10);
    waitAvail(10);
    checkOutput("lm_err", {63'h0, protocol_err}, 64'h1);
    checkOutput("lm_nwrites", 64'(wlog.size() - bW), 64'd3);
    checkOutput("lm_p2_addr", {32'h0, wlog[bW + 1].addr}, {32'h0, expAddr(7, 2)});
    checkOutput("lm_avail_addr", 64'(availLog[bA]), 64'd7);
    hostOp(1, 7, 64'h0);
    applyCommand(8, 0);
    checkOutput("lm_err_sticky", {63'h0, protocol_err}, 64'h1);

    $display("[TB] reset during payload");
    applyStimulus(hdrOf(9, 3), 9, 1'b0, 40);
    applyStimulus(payOf(9, 1), 9, 1'b0, 10);
    bW = wlog.size();
    bA = availLog.size();
    ifc.tdata  = payOf(9, 2);
    ifc.tvalid = 1'b1;
    rstn       = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mr_tready", {63'h0, ifc.tready}, 64'h0);
    @(posedge clk);
    #1;
    ifc.tvalid = 1'b0;
    rstn       = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mr_tready_after", {63'h0, ifc.tready}, 64'h0);
    checkOutput("mr_err", {63'h0, protocol_err}, 64'h0);
    checkOutput("mr_nwrites", 64'(wlog.size() - bW), 64'd0);
    checkOutput("mr_navail", 64'(availLog.size() - bA), 64'd0);
    hostOp(1, 9, 64'h0);
    applyCommand(3, 0);
    checkOutput("mr_idx3", {32'h0, wlog[wlog.size() - 1].addr}, {32'h0, expAddr(3, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
